// File: rtl/mips_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mips_bus_arbiter
// Brief    : Shares one Avalon-MM master bus between the instruction-fetch port
//            and the load/store data port, one registered transfer at a time.
// Revision : 1.0 - initial release
//==============================================================================
module mips_bus_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,

  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        bus_error
);

  localparam logic [2:0]  c_IDLE       = 3'd0;
  localparam logic [2:0]  c_BUSY_I     = 3'd1;
  localparam logic [2:0]  c_BUSY_D     = 3'd2;
  localparam logic [2:0]  c_DONE_I     = 3'd3;
  localparam logic [2:0]  c_DONE_D     = 3'd4;
  localparam logic        c_FIXED_PRIO = (ROUND_ROBIN == 0);
  localparam logic [31:0] c_ABORT_DATA = 32'hDEAD_BEEF;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_last_grant_d;
  logic        w_d_req;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_busy;
  logic        w_timeout;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_rdata;
  logic        r_bus_error;

  assign w_d_req   = d_read | d_write;
  // On a tie the data port wins unless round-robin says the fetch port is due.
  assign w_grant_d = w_d_req && (!i_read || c_FIXED_PRIO || !r_last_grant_d);
  assign w_grant_i = i_read && !w_grant_d;
  assign w_busy    = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
      // Fires on the stall edge that would make the stall count reach the limit.
      assign w_timeout = waitrequest && (r_stall_cnt == c_TIMEOUT_LAST);
    end else begin : g_no_watchdog
      logic w_unused_cnt;
      assign w_unused_cnt = ^r_stall_cnt;
      assign w_timeout    = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_d) begin
          w_next_state = c_BUSY_D;
        end else if (w_grant_i) begin
          w_next_state = c_BUSY_I;
        end
      end
      c_BUSY_I: begin
        if (!waitrequest || w_timeout) begin
          w_next_state = c_DONE_I;
        end
      end
      c_BUSY_D: begin
        if (!waitrequest || w_timeout) begin
          w_next_state = c_DONE_D;
        end
      end
      c_DONE_I: w_next_state = c_IDLE;
      c_DONE_D: w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Requester-side outputs
  always_comb begin
    i_waitrequest = i_read && (r_state != c_DONE_I);
    d_waitrequest = w_d_req && (r_state != c_DONE_D);
    i_readdata    = (r_state == c_DONE_I) ? r_rdata : 32'd0;
    d_readdata    = (r_state == c_DONE_D) ? r_rdata : 32'd0;
  end

  // Bus-side request registers, captured data, last grant, watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant_d <= 1'b1;
      r_stall_cnt    <= 32'd0;
      r_address      <= 32'd0;
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_writedata    <= 32'd0;
      r_byteenable   <= 4'd0;
      r_rdata        <= 32'd0;
      r_bus_error    <= 1'b0;
    end else begin
      if (r_state == c_IDLE) begin
        if (w_grant_d) begin
          r_address      <= d_address;
          r_read         <= d_read && !d_write;
          r_write        <= d_write;
          r_writedata    <= d_writedata;
          r_byteenable   <= d_byteenable;
          r_last_grant_d <= 1'b1;
          r_stall_cnt    <= 32'd0;
        end else if (w_grant_i) begin
          r_address      <= i_address;
          r_read         <= 1'b1;
          r_write        <= 1'b0;
          r_writedata    <= 32'd0;
          r_byteenable   <= 4'b1111;
          r_last_grant_d <= 1'b0;
          r_stall_cnt    <= 32'd0;
        end
      end else if (w_busy) begin
        if (!waitrequest) begin
          r_rdata <= readdata;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end else if (w_timeout) begin
          r_read      <= 1'b0;
          r_write     <= 1'b0;
          r_bus_error <= 1'b1;
          r_rdata     <= c_ABORT_DATA;
        end else begin
          r_stall_cnt <= r_stall_cnt + 32'd1;
        end
      end
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign bus_error  = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mips_bus_arbiter
// Brief    : Scoreboard bench for mips_bus_arbiter with a grant-order model.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

  localparam int MAIN_TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0] i_address, i_readdata, d_address, d_writedata, d_readdata;
  logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
  logic [3:0]  d_byteenable, byteenable;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest, bus_error;

  logic [31:0] f_i_address, f_i_readdata, f_d_address, f_d_writedata, f_d_readdata;
  logic        f_i_read, f_i_waitrequest, f_d_read, f_d_write, f_d_waitrequest;
  logic [3:0]  f_d_byteenable, f_byteenable;
  logic [31:0] f_address, f_writedata, f_readdata;
  logic        f_read, f_write, f_waitrequest, f_bus_error;

  mips_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(MAIN_TO)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .bus_error(bus_error)
  );

  mips_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk(clk), .reset(reset),
    .i_address(f_i_address), .i_read(f_i_read), .i_waitrequest(f_i_waitrequest), .i_readdata(f_i_readdata),
    .d_address(f_d_address), .d_read(f_d_read), .d_write(f_d_write), .d_writedata(f_d_writedata),
    .d_byteenable(f_d_byteenable), .d_waitrequest(f_d_waitrequest), .d_readdata(f_d_readdata),
    .address(f_address), .read(f_read), .write(f_write), .writedata(f_writedata),
    .byteenable(f_byteenable), .waitrequest(f_waitrequest), .readdata(f_readdata), .bus_error(f_bus_error)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_exp_t;

  typedef struct {
    bit          is_d;
    bit          is_rd;
    logic [31:0] data;
    int          stall;
    bit          abort;
  } cmp_exp_t;

  bus_exp_t bus_q[$];
  cmp_exp_t cmp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int force_stall = -1;
  int req_cyc = 0;
  bit single_round = 1'b0;
  bit mdl_last_d = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: random stalls, random read data, checks each bus cycle against the queue
  initial begin : slave
    bit       in_xfer;
    int       stall_left;
    int       stalled;
    bus_exp_t cur;
    cmp_exp_t c;
    in_xfer = 1'b0;
    stall_left = 0;
    stalled = 0;
    waitrequest = 1'b1;
    readdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_xfer = 1'b0;
        waitrequest = 1'b1;
        continue;
      end
      if (in_xfer && !read && !write) begin
        check32("abort_stall_cycles", stalled, MAIN_TO);
        c.is_d = cur.is_d; c.is_rd = cur.rd; c.data = 32'hDEAD_BEEF; c.stall = stalled; c.abort = 1'b1;
        cmp_q.push_back(c);
        in_xfer = 1'b0;
      end else if ((read || write) && !in_xfer) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_xfer: got addr %h with no request outstanding", address);
          cur.is_d = 1'b0; cur.addr = address; cur.rd = read; cur.wr = write;
          cur.wdata = writedata; cur.be = byteenable;
        end else begin
          cur = bus_q.pop_front();
        end
        in_xfer = 1'b1;
        stalled = 0;
        stall_left = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 4));
      end
      if (in_xfer) begin
        check32("bus_address", address, cur.addr);
        check1("bus_read", read, cur.rd);
        check1("bus_write", write, cur.wr);
        check32("bus_byteenable", {28'd0, byteenable}, {28'd0, cur.be});
        if (cur.wr) check32("bus_writedata", writedata, cur.wdata);
        if (stall_left == 0) begin
          waitrequest = 1'b0;
          readdata = $urandom;
          c.is_d = cur.is_d; c.is_rd = cur.rd; c.data = readdata; c.stall = stalled; c.abort = 1'b0;
          cmp_q.push_back(c);
          in_xfer = 1'b0;
        end else begin
          waitrequest = 1'b1;
          stall_left--;
          stalled++;
        end
      end else begin
        waitrequest = 1'b1;
      end
    end
  end

  task automatic got_cmp(bit is_d, logic [31:0] data);
    cmp_exp_t c;
    if (cmp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_completion: port_d=%0d with no bus transfer finished", is_d);
      return;
    end
    c = cmp_q.pop_front();
    check1("completion_port", is_d, c.is_d);
    if (c.is_rd) check32("completion_readdata", data, c.data);
    if (single_round && !c.abort) check32("completion_latency", cyc - req_cyc, 2 + c.stall);
  endtask

  // Monitor: requester-side completions
  initial begin : port_mon
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (i_read && !i_waitrequest) got_cmp(1'b0, i_readdata);
        if ((d_read || d_write) && !d_waitrequest) got_cmp(1'b1, d_readdata);
      end
    end
  end

  task automatic serve(bit is_d);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (is_d ? !d_waitrequest : !i_waitrequest) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL wait_budget: port_d=%0d never completed within 100 cycles", is_d);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_d) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // kind: 0 fetch, 1 data, 2 both; dop: 0 load, 1 store, 2 load+store
  task automatic do_round(int kind, logic [31:0] ia, logic [31:0] da, int dop,
                          logic [31:0] wd, logic [3:0] be);
    bus_exp_t ei, ed;
    bit d_first;
    ei.is_d = 1'b0; ei.addr = ia; ei.rd = 1'b1; ei.wr = 1'b0; ei.wdata = 32'd0; ei.be = 4'hF;
    ed.is_d = 1'b1; ed.addr = da; ed.rd = (dop == 0); ed.wr = (dop != 0); ed.wdata = wd; ed.be = be;
    if (kind == 0) begin
      bus_q.push_back(ei);
      mdl_last_d = 1'b0;
    end else if (kind == 1) begin
      bus_q.push_back(ed);
      mdl_last_d = 1'b1;
    end else begin
      d_first = !mdl_last_d;
      if (d_first) begin bus_q.push_back(ed); bus_q.push_back(ei); end
      else         begin bus_q.push_back(ei); bus_q.push_back(ed); end
      mdl_last_d = !d_first;
    end
    single_round = (kind != 2);
    @(posedge clk);
    #1;
    req_cyc = cyc;
    if (kind != 1) begin
      i_address = ia;
      i_read = 1'b1;
    end
    if (kind != 0) begin
      d_address = da;
      d_read = (dop != 1);
      d_write = (dop != 0);
      d_writedata = wd;
      d_byteenable = be;
    end
    if (kind == 0)      serve(1'b0);
    else if (kind == 1) serve(1'b1);
    else begin
      fork
        serve(1'b0);
        serve(1'b1);
      join
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic random_round();
    do_round(int'($urandom_range(0, 2)), {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC,
             $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)), $urandom,
             4'($urandom_range(0, 15)));
  endtask

  task automatic fixed_priority_pair(logic [31:0] ia, logic [31:0] da);
    logic [31:0] first_addr, second_addr;
    int nseen, n;
    bit drop_i, drop_d, done_i, done_d;
    first_addr = 32'd0; second_addr = 32'd0;
    nseen = 0; n = 0; done_i = 1'b0; done_d = 1'b0;
    @(posedge clk);
    #1;
    f_i_address = ia; f_d_address = da;
    f_i_read = 1'b1; f_d_read = 1'b1; f_d_write = 1'b0;
    while (!(done_i && done_d) && n < 40) begin
      @(negedge clk);
      n++;
      drop_i = 1'b0; drop_d = 1'b0;
      if (f_read) begin
        if (nseen == 0) first_addr = f_address;
        else if (nseen == 1) second_addr = f_address;
        nseen++;
      end
      if (f_i_read && !f_i_waitrequest) begin
        check32("fp_fetch_readdata", f_i_readdata, 32'h0BAD_F00D);
        drop_i = 1'b1; done_i = 1'b1;
      end
      if (f_d_read && !f_d_waitrequest) begin
        check32("fp_load_readdata", f_d_readdata, 32'h0BAD_F00D);
        drop_d = 1'b1; done_d = 1'b1;
      end
      @(posedge clk);
      #1;
      if (drop_i) f_i_read = 1'b0;
      if (drop_d) f_d_read = 1'b0;
    end
    check1("fp_both_completed", done_i && done_d, 1'b1);
    check32("fp_first_grant_is_data", first_addr, da);
    check32("fp_second_grant_is_fetch", second_addr, ia);
  endtask

  initial begin : stimulus
    int n;
    reset = 1'b0;
    i_read = 1'b0; i_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0; d_writedata = 32'd0; d_byteenable = 4'd0;
    f_i_read = 1'b0; f_i_address = 32'd0;
    f_d_read = 1'b0; f_d_write = 1'b0; f_d_address = 32'd0; f_d_writedata = 32'd0; f_d_byteenable = 4'hF;
    f_waitrequest = 1'b0; f_readdata = 32'h0BAD_F00D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset_read", read, 1'b0);
    check1("reset_write", write, 1'b0);
    check32("reset_address", address, 32'd0);
    check32("reset_byteenable", {28'd0, byteenable}, 32'd0);
    check1("reset_bus_error", bus_error, 1'b0);
    check1("reset_i_waitrequest", i_waitrequest, 1'b0);
    check1("reset_d_waitrequest", d_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Simultaneous requests from reset, twice: fetch first, then alternates
    do_round(2, 32'h0000_1000, 32'h0000_2000, 0, 32'd0, 4'hF);
    do_round(2, 32'h0000_1004, 32'h0000_2004, 0, 32'd0, 4'hF);

    force_stall = 0;
    do_round(0, 32'hBFC0_0000, 32'd0, 0, 32'd0, 4'h0);
    force_stall = 4;
    do_round(1, 32'd0, 32'h0000_0400, 1, 32'h1234_5678, 4'b0011);
    force_stall = 1;
    do_round(1, 32'd0, 32'h0000_0800, 2, 32'hCAFE_F00D, 4'b1100);
    force_stall = -1;

    for (int i = 0; i < 40; i++) random_round();
    check1("bus_error_before_timeout", bus_error, 1'b0);

    force_stall = 1000;
    do_round(0, 32'h0000_0040, 32'd0, 0, 32'd0, 4'h0);
    force_stall = -1;
    check1("bus_error_after_timeout", bus_error, 1'b1);
    do_round(2, 32'h0000_0044, 32'h0000_0048, 0, 32'd0, 4'hF);
    check1("bus_error_sticky", bus_error, 1'b1);

    // Reset in the middle of a stalled store
    force_stall = 1000;
    begin
      bus_exp_t ed;
      ed.is_d = 1'b1; ed.addr = 32'h0000_0C00; ed.rd = 1'b0; ed.wr = 1'b1;
      ed.wdata = 32'hA5A5_5A5A; ed.be = 4'hF;
      bus_q.push_back(ed);
    end
    single_round = 1'b0;
    @(posedge clk);
    #1;
    d_address = 32'h0000_0C00; d_write = 1'b1; d_read = 1'b0;
    d_writedata = 32'hA5A5_5A5A; d_byteenable = 4'hF;
    n = 0;
    while (!write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1("reset_test_write_started", write, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check1("async_reset_read", read, 1'b0);
    check1("async_reset_write", write, 1'b0);
    check1("async_reset_bus_error", bus_error, 1'b0);
    d_write = 1'b0;
    bus_q.delete();
    cmp_q.delete();
    force_stall = -1;
    mdl_last_d = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("post_reset_no_strobe", read | write, 1'b0);
      check1("post_reset_no_pending", i_waitrequest | d_waitrequest, 1'b0);
    end

    for (int i = 0; i < 10; i++) random_round();
    do_round(2, 32'h0000_3000, 32'h0000_3004, 2, 32'h0F0F_0F0F, 4'b1010);

    fixed_priority_pair(32'h0000_5000, 32'h0000_6000);
    fixed_priority_pair(32'h0000_5004, 32'h0000_6004);

    repeat (3) @(posedge clk);
    check32("scoreboard_bus_queue_drained", bus_q.size(), 32'd0);
    check32("scoreboard_completion_queue_drained", cmp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : global_budget
    #500_000;
    $display("FAIL global_time_budget: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time budget exhausted");
  end

endmodule
`default_nettype wire
